// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its decoder.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_LOAD, CL_STORE, CL_ALU, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI
  } iclass_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_IDLE = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] MEMRD_WORD = 3'b111;
  localparam logic [2:0] MEMRD_BYTE = 3'b000;

  typedef struct packed {
    iclass_t    cls;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] imm_src;
    logic [3:0] mem_write;
    logic [2:0] mem_read;
    logic       illegal;
  } dec_t;

  // funct3 -> ALU op for the arithmetic/logic forms this ALU supports; anything else adds.
  function automatic logic [2:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decode: IR -> class, ALU/imm/memory controls and legality.
module mc_decoder import control_pkg::*; (
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_ir;

  assign op        = ir[6:0];
  assign f3        = ir[14:12];
  assign f7        = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  always_comb begin
    dec = '{cls: CL_NONE, alu_ctrl: ALU_ADD, alu_src: 1'b1, imm_src: IMM_I,
            mem_write: 4'b0000, mem_read: MEMRD_WORD, illegal: 1'b1};
    case (op)
      OP_LOAD: if (f3 inside {3'b000, 3'b010, 3'b100}) begin
        dec.cls      = CL_LOAD;
        dec.illegal  = 1'b0;
        dec.mem_read = (f3 == 3'b010) ? MEMRD_WORD : MEMRD_BYTE;
      end
      OP_IMM: if (f3 inside {3'b000, 3'b010, 3'b110, 3'b111}) begin
        dec.cls      = CL_ALU;
        dec.illegal  = 1'b0;
        dec.alu_ctrl = alu_of_f3(f3);
      end
      OP_STORE: if (f3 inside {3'b000, 3'b010}) begin
        dec.cls       = CL_STORE;
        dec.illegal   = 1'b0;
        dec.imm_src   = IMM_S;
        dec.mem_write = (f3 == 3'b010) ? 4'b1111 : 4'b0001;
      end
      OP_BRANCH: if (f3 inside {3'b000, 3'b001, 3'b100, 3'b101}) begin
        dec.cls      = CL_BRANCH;
        dec.illegal  = 1'b0;
        dec.alu_ctrl = ALU_SUB;
        dec.alu_src  = 1'b0;
        dec.imm_src  = IMM_B;
      end
      OP_JAL: begin
        dec.cls     = CL_JAL;
        dec.illegal = 1'b0;
        dec.imm_src = IMM_J;
      end
      OP_JALR: if (f3 == 3'b000) begin
        dec.cls     = CL_JALR;
        dec.illegal = 1'b0;
      end
      OP_LUI: begin
        dec.cls     = CL_LUI;
        dec.illegal = 1'b0;
        dec.imm_src = IMM_U;
      end
      // Only funct7 0100000 (sub) is accepted besides the base encoding.
      OP_R: if (f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'b000)) begin
        dec.cls      = CL_ALU;
        dec.illegal  = 1'b0;
        dec.alu_src  = 1'b0;
        dec.alu_ctrl = f7[5] ? ALU_SUB : alu_of_f3(f3);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: IR capture, FETCH/DECODE/EXEC/MEM/WB sequencing, memory timeout and trap.
module multicycle_control_unit import control_pkg::*; #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_TIMEOUT = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_IR    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  mem_ready,
  input  logic                  EQ,
  input  logic                  LT,
  output logic                  mem_req,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  JALsrc,
  output logic                  JALRsrc,
  output logic                  RegWrite,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic [2:0]            ImmSrc,
  output logic [3:0]            MEMWrite,
  output logic [2:0]            MEMRead,
  output logic                  MEMsrc,
  output logic                  instr_retired,
  output logic                  trap
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t                state, state_nx;
  logic                  run;
  logic [DATA_WIDTH-1:0] ir;
  logic [CW-1:0]         wait_cnt;
  dec_t                  dec;
  logic                  fetch_done, waiting, timeout, taken;

  mc_decoder u_dec (.ir(ir[31:0]), .dec(dec));

  // run holds the outputs quiet while reset is asserted; FETCH starts on the first edge after release.
  assign mem_req    = run && (state == FETCH || state == MEM);
  assign fetch_done = (state == FETCH) && mem_req && mem_ready;
  assign waiting    = mem_req && !mem_ready;
  assign timeout    = waiting && (wait_cnt == CW'(MEM_TIMEOUT - 1));
  assign trap       = (state == TRAP);

  always_comb begin
    case (ir[14:12])
      3'b000:  taken = EQ;
      3'b001:  taken = !EQ;
      3'b100:  taken = LT;
      3'b101:  taken = !LT;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  if (timeout) state_nx = TRAP;
              else if (fetch_done) state_nx = DECODE;
      DECODE: state_nx = dec.illegal ? TRAP : EXEC;
      EXEC: begin
        case (dec.cls)
          CL_BRANCH:          state_nx = FETCH;
          CL_LOAD, CL_STORE:  state_nx = MEM;
          default:            state_nx = WB;
        endcase
      end
      MEM:    if (timeout) state_nx = TRAP;
              else if (mem_ready) state_nx = (dec.cls == CL_STORE) ? FETCH : WB;
      WB:     state_nx = FETCH;
      TRAP:   state_nx = TRAP;
      default: state_nx = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      run      <= 1'b0;
      ir       <= RESET_IR;
      wait_cnt <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      if (fetch_done) ir <= instr;
      // mem_ready on the limit cycle leaves timeout low, so the transfer wins over the trap.
      if (state_nx != state || mem_ready) wait_cnt <= '0;
      else if (waiting)                   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCsrc         = 1'b0;
    JALsrc        = 1'b0;
    JALRsrc       = 1'b0;
    RegWrite      = 1'b0;
    ALUctrl       = ALU_IDLE;
    ALUsrc        = 1'b0;
    ImmSrc        = IMM_I;
    MEMWrite      = 4'b0000;
    MEMRead       = MEMRD_WORD;
    MEMsrc        = 1'b0;
    instr_retired = 1'b0;
    case (state)
      FETCH: begin
        IRWrite = fetch_done;
        PCWrite = fetch_done;
      end
      DECODE: ImmSrc = dec.imm_src;
      EXEC: begin
        ImmSrc  = dec.imm_src;
        ALUctrl = dec.alu_ctrl;
        ALUsrc  = dec.alu_src;
        case (dec.cls)
          CL_BRANCH: begin
            PCWrite       = 1'b1;
            PCsrc         = taken;
            instr_retired = 1'b1;
          end
          CL_JAL: begin
            PCWrite = 1'b1;
            PCsrc   = 1'b1;
          end
          CL_JALR: begin
            PCWrite = 1'b1;
            JALRsrc = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        ImmSrc        = dec.imm_src;
        MEMWrite      = run ? dec.mem_write : 4'b0000;
        MEMRead       = dec.mem_read;
        instr_retired = (dec.cls == CL_STORE) && mem_ready;
      end
      WB: begin
        ImmSrc        = dec.imm_src;
        RegWrite      = 1'b1;
        MEMsrc        = (dec.cls == CL_LOAD);
        JALsrc        = (dec.cls == CL_JAL) || (dec.cls == CL_JALR);
        instr_retired = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed + randomized bench for multicycle_control_unit against a mnemonic-table reference model.
module tb_multicycle_control_unit;

  localparam int TO = 16;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0, EQ = 1'b0, LT = 1'b0;
  logic        mem_req, IRWrite, PCWrite, PCsrc, JALsrc, JALRsrc, RegWrite, ALUsrc, MEMsrc;
  logic        instr_retired, trap;
  logic [2:0]  ALUctrl, ImmSrc, MEMRead;
  logic [3:0]  MEMWrite;

  multicycle_control_unit #(.DATA_WIDTH(32), .MEM_TIMEOUT(TO), .RESET_IR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .EQ(EQ), .LT(LT),
    .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc), .JALsrc(JALsrc),
    .JALRsrc(JALRsrc), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .MEMWrite(MEMWrite), .MEMRead(MEMRead), .MEMsrc(MEMsrc), .instr_retired(instr_retired), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] op;
    int         f3;    // -1: field is immediate bits, randomized
    int         f7;
    int         kind;
    int         cond;  // branches: 0 eq, 1 ne, 2 lt, 3 ge
    logic [2:0] alu;
    logic       alusrc;
    logic [2:0] imm;
    logic [3:0] mw;
    logic [2:0] mr;
  } ent_t;

  ent_t tab[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input string nm, input logic [6:0] op, input int f3, input int f7, input int kind,
                     input int cond, input logic [2:0] alu, input logic src, input logic [2:0] imm,
                     input logic [3:0] mw, input logic [2:0] mr);
    ent_t e;
    e.name = nm; e.op = op; e.f3 = f3; e.f7 = f7; e.kind = kind; e.cond = cond;
    e.alu = alu; e.alusrc = src; e.imm = imm; e.mw = mw; e.mr = mr;
    tab.push_back(e);
  endtask

  function automatic ent_t find(input string nm);
    foreach (tab[i]) if (tab[i].name == nm) return tab[i];
    return tab[0];
  endfunction

  function automatic logic [31:0] enc(input ent_t e);
    logic [31:0] w;
    w = $urandom();
    w[6:0] = e.op;
    if (e.f3 >= 0) w[14:12] = e.f3[2:0];
    if (e.f7 >= 0) w[31:25] = e.f7[6:0];
    return w;
  endfunction

  function automatic logic [31:0] strobes();
    return {18'b0, mem_req, IRWrite, PCWrite, PCsrc, JALsrc, JALRsrc, RegWrite, MEMsrc,
            instr_retired, trap, MEMWrite};
  endfunction

  function automatic logic [31:0] ev(input bit req, input bit irw, input bit pcw, input bit pcs,
                                     input bit jl, input bit jr, input bit rw, input bit ms,
                                     input bit ret, input bit tr, input logic [3:0] mwr);
    return {18'b0, req, irw, pcw, pcs, jl, jr, rw, ms, ret, tr, mwr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Entered just after a rising edge; leaves the unit in its first FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("reset strobes", strobes(), ev(0,0,0,0,0,0,0,0,0,0,4'h0));
    chk("reset ALUctrl", 32'(ALUctrl), 32'd7);
    chk("reset MEMRead", 32'(MEMRead), 32'd7);
    chk("reset ImmSrc", 32'(ImmSrc), 32'd0);
    chk("reset IR", dut.ir, 32'h0000_0013);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_instr(input ent_t e, input logic [31:0] w, input int fw, input int mw,
                           input logic eq, input logic lt, input bit rst_in_mem);
    bit tk, ls;
    for (int i = 0; i < fw && i < TO; i++) begin
      mem_ready = 1'b0; instr = $urandom();
      @(negedge clk);
      chk($sformatf("%s fetch-wait%0d", e.name, i), strobes(), ev(1,0,0,0,0,0,0,0,0,0,4'h0));
      tick();
    end
    if (fw >= TO) begin
      @(negedge clk);
      chk($sformatf("%s fetch-timeout", e.name), strobes(), ev(0,0,0,0,0,0,0,0,0,1,4'h0));
      return;
    end
    mem_ready = 1'b1; instr = w;
    @(negedge clk);
    chk($sformatf("%s fetch", e.name), strobes(), ev(1,1,1,0,0,0,0,0,0,0,4'h0));
    chk($sformatf("%s fetch ALUctrl", e.name), 32'(ALUctrl), 32'd7);
    tick();
    mem_ready = rbit(); instr = $urandom(); EQ = rbit(); LT = rbit();
    @(negedge clk);
    chk($sformatf("%s decode", e.name), strobes(), ev(0,0,0,0,0,0,0,0,0,0,4'h0));
    chk($sformatf("%s ImmSrc", e.name), 32'(ImmSrc), 32'(e.imm));
    tick();
    EQ = eq; LT = lt; mem_ready = rbit();
    case (e.cond)
      0: tk = eq;
      1: tk = !eq;
      2: tk = lt;
      default: tk = !lt;
    endcase
    @(negedge clk);
    chk($sformatf("%s exec", e.name), strobes(),
        ev(0, 0, e.kind inside {K_BR, K_JAL, K_JALR}, (e.kind == K_BR) ? tk : (e.kind == K_JAL),
           0, e.kind == K_JALR, 0, 0, e.kind == K_BR, 0, 4'h0));
    chk($sformatf("%s ALUctrl", e.name), 32'(ALUctrl), 32'(e.alu));
    chk($sformatf("%s ALUsrc", e.name), 32'(ALUsrc), 32'(e.alusrc));
    tick();
    if (e.kind == K_BR) return;
    ls = (e.kind == K_LOAD);
    if (e.kind == K_LOAD || e.kind == K_STORE) begin
      if (rst_in_mem) begin
        mem_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("%s pre-reset mem", e.name), strobes(), ev(1,0,0,0,0,0,0,0,0,0,e.mw));
        #1 rst_n = 1'b0;
        #1;
        chk($sformatf("%s reset-mid-mem", e.name), strobes(), ev(0,0,0,0,0,0,0,0,0,0,4'h0));
        chk($sformatf("%s reset-mid-mem IR", e.name), dut.ir, 32'h0000_0013);
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      for (int i = 0; i < mw && i < TO; i++) begin
        mem_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("%s mem-wait%0d", e.name, i), strobes(), ev(1,0,0,0,0,0,0,0,0,0,e.mw));
        if (ls) chk($sformatf("%s MEMRead wait%0d", e.name, i), 32'(MEMRead), 32'(e.mr));
        tick();
      end
      if (mw >= TO) begin
        @(negedge clk);
        chk($sformatf("%s mem-timeout", e.name), strobes(), ev(0,0,0,0,0,0,0,0,0,1,4'h0));
        return;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("%s mem", e.name), strobes(), ev(1,0,0,0,0,0,0,0,!ls,0,e.mw));
      if (ls) chk($sformatf("%s MEMRead", e.name), 32'(MEMRead), 32'(e.mr));
      tick();
      if (!ls) return;
    end
    mem_ready = rbit();
    @(negedge clk);
    chk($sformatf("%s wb", e.name), strobes(),
        ev(0,0,0,0, e.kind inside {K_JAL, K_JALR}, 0, 1, ls, 1, 0, 4'h0));
    tick();
  endtask

  task automatic run_illegal(input logic [31:0] w, input int ncyc);
    mem_ready = 1'b1; instr = w;
    @(negedge clk);
    chk($sformatf("illegal %h fetch", w), strobes(), ev(1,1,1,0,0,0,0,0,0,0,4'h0));
    tick();
    mem_ready = rbit();
    @(negedge clk);
    chk($sformatf("illegal %h decode", w), strobes(), ev(0,0,0,0,0,0,0,0,0,0,4'h0));
    tick();
    for (int i = 0; i < ncyc; i++) begin
      mem_ready = rbit(); EQ = rbit(); LT = rbit();
      @(negedge clk);
      chk($sformatf("illegal %h trap%0d", w, i), strobes(), ev(0,0,0,0,0,0,0,0,0,1,4'h0));
      tick();
    end
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t e;
    add("addi", 7'b0010011, 0, -1, K_ALU, 0, 3'b000, 1, 3'b000, 4'h0, 3'b111);
    add("slti", 7'b0010011, 2, -1, K_ALU, 0, 3'b101, 1, 3'b000, 4'h0, 3'b111);
    add("ori",  7'b0010011, 6, -1, K_ALU, 0, 3'b011, 1, 3'b000, 4'h0, 3'b111);
    add("andi", 7'b0010011, 7, -1, K_ALU, 0, 3'b010, 1, 3'b000, 4'h0, 3'b111);
    add("lw",   7'b0000011, 2, -1, K_LOAD, 0, 3'b000, 1, 3'b000, 4'h0, 3'b111);
    add("lb",   7'b0000011, 0, -1, K_LOAD, 0, 3'b000, 1, 3'b000, 4'h0, 3'b000);
    add("lbu",  7'b0000011, 4, -1, K_LOAD, 0, 3'b000, 1, 3'b000, 4'h0, 3'b000);
    add("sw",   7'b0100011, 2, -1, K_STORE, 0, 3'b000, 1, 3'b001, 4'hF, 3'b111);
    add("sb",   7'b0100011, 0, -1, K_STORE, 0, 3'b000, 1, 3'b001, 4'h1, 3'b111);
    add("beq",  7'b1100011, 0, -1, K_BR, 0, 3'b001, 0, 3'b010, 4'h0, 3'b111);
    add("bne",  7'b1100011, 1, -1, K_BR, 1, 3'b001, 0, 3'b010, 4'h0, 3'b111);
    add("blt",  7'b1100011, 4, -1, K_BR, 2, 3'b001, 0, 3'b010, 4'h0, 3'b111);
    add("bge",  7'b1100011, 5, -1, K_BR, 3, 3'b001, 0, 3'b010, 4'h0, 3'b111);
    add("jal",  7'b1101111, -1, -1, K_JAL, 0, 3'b000, 1, 3'b011, 4'h0, 3'b111);
    add("jalr", 7'b1100111, 0, -1, K_JALR, 0, 3'b000, 1, 3'b000, 4'h0, 3'b111);
    add("lui",  7'b0110111, -1, -1, K_ALU, 0, 3'b000, 1, 3'b100, 4'h0, 3'b111);
    add("add",  7'b0110011, 0, 0, K_ALU, 0, 3'b000, 0, 3'b000, 4'h0, 3'b111);
    add("sub",  7'b0110011, 0, 32, K_ALU, 0, 3'b001, 0, 3'b000, 4'h0, 3'b111);
    add("slt",  7'b0110011, 2, 0, K_ALU, 0, 3'b101, 0, 3'b000, 4'h0, 3'b111);
    add("or",   7'b0110011, 6, 0, K_ALU, 0, 3'b011, 0, 3'b000, 4'h0, 3'b111);
    add("and",  7'b0110011, 7, 0, K_ALU, 0, 3'b010, 0, 3'b000, 4'h0, 3'b111);

    do_reset();

    run_instr(find("addi"), 32'h0050_0093, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(find("lw"),   32'h0000_A103, 0, 3, 1'b0, 1'b0, 1'b0);
    e = find("blt");
    run_instr(e, enc(e), 0, 0, rbit(), 1'b1, 1'b0);
    run_instr(e, enc(e), 0, 0, rbit(), 1'b0, 1'b0);
    run_instr(find("addi"), 32'h0000_0013, 1, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      e = tab[$urandom_range(0, tab.size() - 1)];
      run_instr(e, enc(e), $urandom_range(0, 3), $urandom_range(0, 4), rbit(), rbit(), 1'b0);
    end

    // A transfer completing on the last permitted cycle must not trap.
    e = find("lw");
    run_instr(e, enc(e), 0, TO - 1, 1'b0, 1'b0, 1'b0);
    e = find("addi");
    run_instr(e, enc(e), TO - 1, 0, 1'b0, 1'b0, 1'b0);

    run_illegal(32'hFFFF_FFFF, 20);
    run_illegal(32'h0000_1003, 2);
    run_illegal(32'h0000_4023, 2);
    run_illegal(32'h4000_1033, 2);
    run_illegal(32'h0000_1067, 2);
    run_illegal(32'h0000_0000, 2);

    e = find("sb");
    run_instr(e, enc(e), 0, TO, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();
    e = find("addi");
    run_instr(e, enc(e), TO, 0, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();

    e = find("sw");
    run_instr(e, enc(e), 0, 0, 1'b0, 1'b0, 1'b1);
    run_instr(find("addi"), 32'h0050_0093, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
